// File: rtl/conf_axi_arbiter_if.sv
// AXI4-Lite master bus between the two-requester arbiter and a single slave.
interface conf_axi_arbiter_if;
  logic        AxiWriteAddrValid_ValOut;
  logic        AxiWriteAddrReady_RdyIn;
  logic [31:0] AxiWriteAddrAddress_AdrOut;
  logic [2:0]  AxiWriteAddrProt_DatOut;
  logic        AxiWriteDataValid_ValOut;
  logic        AxiWriteDataReady_RdyIn;
  logic [31:0] AxiWriteDataData_DatOut;
  logic [3:0]  AxiWriteDataStrobe_DatOut;
  logic        AxiWriteRespValid_ValIn;
  logic        AxiWriteRespReady_RdyOut;
  logic [1:0]  AxiWriteRespResponse_DatIn;
  logic        AxiReadAddrValid_ValOut;
  logic        AxiReadAddrReady_RdyIn;
  logic [31:0] AxiReadAddrAddress_AdrOut;
  logic [2:0]  AxiReadAddrProt_DatOut;
  logic        AxiReadDataValid_ValIn;
  logic        AxiReadDataReady_RdyOut;
  logic [1:0]  AxiReadDataResponse_DatIn;
  logic [31:0] AxiReadDataData_DatIn;

  modport master (
    output AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
    input  AxiWriteAddrReady_RdyIn,
    output AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
    input  AxiWriteDataReady_RdyIn,
    input  AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn,
    output AxiWriteRespReady_RdyOut,
    output AxiReadAddrValid_ValOut, AxiReadAddrAddress_AdrOut, AxiReadAddrProt_DatOut,
    input  AxiReadAddrReady_RdyIn,
    input  AxiReadDataValid_ValIn, AxiReadDataResponse_DatIn, AxiReadDataData_DatIn,
    output AxiReadDataReady_RdyOut
  );

  modport slave (
    input  AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
    output AxiWriteAddrReady_RdyIn,
    input  AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
    output AxiWriteDataReady_RdyIn,
    output AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn,
    input  AxiWriteRespReady_RdyOut,
    input  AxiReadAddrValid_ValOut, AxiReadAddrAddress_AdrOut, AxiReadAddrProt_DatOut,
    output AxiReadAddrReady_RdyIn,
    output AxiReadDataValid_ValIn, AxiReadDataResponse_DatIn, AxiReadDataData_DatIn,
    input  AxiReadDataReady_RdyOut
  );
endinterface

// File: rtl/conf_axi_arbiter.sv
// Round-robin arbiter funnelling two simple request/ack ports onto one
// AXI4-Lite master, with an optional per-access timeout.
//
//   state   | meaning
//   Idle    | waiting for a request; grants and latches it
//   Access  | address/data channels in flight (response may overlap)
//   Resp    | address phase done, waiting for B or R
//   Ack     | one-cycle Ack pulse to the granted requester
module conf_axi_arbiter #(
  parameter int unsigned AxiTimeout_Gen = 0,
  parameter int unsigned NumReq_Gen     = 2
) (
  input  logic                    SysClk_ClkIn,
  input  logic                    SysRstN_RstIn,
  input  logic [NumReq_Gen-1:0]   Req_ValIn,
  input  logic [NumReq_Gen-1:0]   ReqWrite_DatIn,
  input  logic [32*NumReq_Gen-1:0] ReqAddr_AdrIn,
  input  logic [32*NumReq_Gen-1:0] ReqData_DatIn,
  output logic [NumReq_Gen-1:0]   Ack_ValOut,
  output logic [31:0]             RdData_DatOut,
  output logic [2:0]              Resp_DatOut,
  conf_axi_arbiter_if.master      axi
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;
  localparam logic [1:0] StAck    = 2'd3;

  logic [1:0]  state, stNext;
  logic        prio, grantIdx, grantNext;
  logic [31:0] addrReg, dataReg, timeoutCnt;
  logic [3:0]  strobe;
  logic        awValid, wValid, bReady, arValid, rReady, respSeen;
  logic        grant, busy, addrDone, bHs, rHs, rspHs, timeoutHit, finishOk, abort;

  assign axi.AxiWriteAddrValid_ValOut   = awValid;
  assign axi.AxiWriteAddrAddress_AdrOut = addrReg;
  assign axi.AxiWriteAddrProt_DatOut    = 3'b000;
  assign axi.AxiWriteDataValid_ValOut   = wValid;
  assign axi.AxiWriteDataData_DatOut    = dataReg;
  assign axi.AxiWriteDataStrobe_DatOut  = strobe;
  assign axi.AxiWriteRespReady_RdyOut   = bReady;
  assign axi.AxiReadAddrValid_ValOut    = arValid;
  assign axi.AxiReadAddrAddress_AdrOut  = addrReg;
  assign axi.AxiReadAddrProt_DatOut     = 3'b000;
  assign axi.AxiReadDataReady_RdyOut    = rReady;

  assign grant = (state == StIdle) && (|Req_ValIn);
  assign busy  = (state == StAccess) || (state == StResp);
  // Address phase is complete once no address/data valid is left without its ready.
  assign addrDone = !((awValid && !axi.AxiWriteAddrReady_RdyIn) ||
                      (wValid && !axi.AxiWriteDataReady_RdyIn) ||
                      (arValid && !axi.AxiReadAddrReady_RdyIn));
  assign bHs   = bReady && axi.AxiWriteRespValid_ValIn;
  assign rHs   = rReady && axi.AxiReadDataValid_ValIn;
  assign rspHs = bHs || rHs;
  assign timeoutHit = (AxiTimeout_Gen != 0) && (timeoutCnt == AxiTimeout_Gen - 32'd1);
  // A response arriving on the timeout cycle takes precedence over the abort.
  assign finishOk = ((state == StAccess) && addrDone && (rspHs || respSeen)) ||
                    ((state == StResp) && rspHs);
  assign abort = busy && timeoutHit && !finishOk;

  // Round-robin pick: on contention take the favoured requester.
  always_comb begin
    grantNext = 1'b0;
    if (Req_ValIn[0] && Req_ValIn[1]) grantNext = prio;
    else if (Req_ValIn[1])            grantNext = 1'b1;
  end

  // Next-state decode.
  always_comb begin
    stNext = state;
    case (state)
      StIdle:   if (grant) stNext = StAccess;
      StAccess: if (finishOk || abort) stNext = StAck;
                else if (addrDone)     stNext = StResp;
      StResp:   if (finishOk || abort) stNext = StAck;
      StAck:    stNext = StIdle;
      default:  stNext = StIdle;
    endcase
  end

  // State register, round-robin pointer and request latch.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state    <= StIdle;
      prio     <= 1'b0;
      grantIdx <= 1'b0;
      addrReg  <= '0;
      dataReg  <= '0;
      strobe   <= '0;
    end else begin
      state <= stNext;
      if (grant) begin
        grantIdx <= grantNext;
        prio     <= ~grantNext;
        addrReg  <= ReqAddr_AdrIn[{grantNext, 5'b0} +: 32];
        dataReg  <= ReqData_DatIn[{grantNext, 5'b0} +: 32];
        strobe   <= ReqWrite_DatIn[grantNext] ? 4'b1111 : 4'b0000;
      end
    end
  end

  // AXI valids/readies: raised at grant, each dropped on its own handshake, all dropped on abort.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      awValid <= 1'b0;
      wValid  <= 1'b0;
      bReady  <= 1'b0;
      arValid <= 1'b0;
      rReady  <= 1'b0;
    end else if (grant) begin
      awValid <= ReqWrite_DatIn[grantNext];
      wValid  <= ReqWrite_DatIn[grantNext];
      bReady  <= ReqWrite_DatIn[grantNext];
      arValid <= ~ReqWrite_DatIn[grantNext];
      rReady  <= ~ReqWrite_DatIn[grantNext];
    end else if (abort) begin
      awValid <= 1'b0;
      wValid  <= 1'b0;
      bReady  <= 1'b0;
      arValid <= 1'b0;
      rReady  <= 1'b0;
    end else begin
      if (awValid && axi.AxiWriteAddrReady_RdyIn) awValid <= 1'b0;
      if (wValid && axi.AxiWriteDataReady_RdyIn)  wValid  <= 1'b0;
      if (arValid && axi.AxiReadAddrReady_RdyIn)  arValid <= 1'b0;
      if (bHs) bReady <= 1'b0;
      if (rHs) rReady <= 1'b0;
    end
  end

  // Response capture; an early B/R is held until the address phase finishes.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      RdData_DatOut <= '0;
      Resp_DatOut   <= '0;
      respSeen      <= 1'b0;
    end else if (grant) begin
      respSeen <= 1'b0;
    end else if (abort) begin
      RdData_DatOut <= '0;
      Resp_DatOut   <= 3'b100;
    end else if (busy && rspHs) begin
      RdData_DatOut <= rHs ? axi.AxiReadDataData_DatIn : 32'h0;
      Resp_DatOut   <= {1'b0, bHs ? axi.AxiWriteRespResponse_DatIn : axi.AxiReadDataResponse_DatIn};
      respSeen      <= 1'b1;
    end
  end

  // One-cycle Ack to the granted requester on entry to Ack.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) Ack_ValOut <= '0;
    else if ((stNext == StAck) && (state != StAck)) Ack_ValOut <= grantIdx ? 2'b10 : 2'b01;
    else Ack_ValOut <= '0;
  end

  // Access timer: cleared at grant, counts while the access is outstanding.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn)  timeoutCnt <= '0;
    else if (grant)      timeoutCnt <= '0;
    else if (busy)       timeoutCnt <= timeoutCnt + 32'd1;
  end

endmodule
